// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for the 8-bit ALU datapath.
// Decodes a latched opcode into ALU select lines, chains the carry for
// 16-bit add/subtract across two execute cycles, owns the {C,N,Z} flag
// register and strobes register-file writes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; ALU driven to a harmless ZERO result
// EXEC     | single 8-bit op, or low byte of ADD16/SUB16
// EXEC_HI  | high byte of ADD16/SUB16, carry taken from updated C flag
module alu_seq_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] op,
   input  logic [2:0] alu_flags,
   output logic       sel_a_mux,
   output logic       sel_b_mux,
   output logic       sel_gd_b_mux,
   output logic       sel_bit_mux,
   output logic       sel_shift_mux,
   output logic       shift_dir,
   output logic       shift_mode,
   output logic [3:0] sel_out_mux,
   output logic [2:0] flags_q,
   output logic       busy,
   output logic       done,
   output logic       wr_en,
   output logic       byte_sel
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC    = 2'd1,
      S_EXEC_HI = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOT   = 4'd0;
   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_ADC   = 4'd5;
   localparam logic [3:0] OP_SUB   = 4'd6;
   localparam logic [3:0] OP_SBC   = 4'd7;
   localparam logic [3:0] OP_LSL1  = 4'd8;
   localparam logic [3:0] OP_LSR1  = 4'd9;
   localparam logic [3:0] OP_ASR1  = 4'd10;
   localparam logic [3:0] OP_LSLB  = 4'd11;
   localparam logic [3:0] OP_CMP   = 4'd12;
   localparam logic [3:0] OP_ADD16 = 4'd13;
   localparam logic [3:0] OP_SUB16 = 4'd14;
   localparam logic [3:0] OP_CLR   = 4'd15;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [2:0] flags_d;
   logic [3:0] eff_op;
   logic       c_q;

   assign c_q = flags_q[2];

   // State, latched opcode and flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         flags_q <= 3'b000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         flags_q <= flags_d;
      end
   end

   // Next state, opcode latch and flag update at the end of each execute cycle
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op_q == OP_ADD16 || op_q == OP_SUB16) state_d = S_EXEC_HI;
            else                                      state_d = S_IDLE;
            if ((op_q >= OP_ADD && op_q <= OP_SBC) || op_q == OP_CMP ||
                op_q == OP_ADD16 || op_q == OP_SUB16)
               flags_d = alu_flags;
         end
         S_EXEC_HI: begin
            state_d = S_IDLE;
            // Z survives only if both bytes of the 16-bit result are zero
            flags_d = {alu_flags[2:1], alu_flags[0] & flags_q[0]};
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU control decode from registered state and latched opcode
   always_comb begin
      sel_a_mux     = 1'b0;
      sel_b_mux     = 1'b0;
      sel_gd_b_mux  = 1'b0;
      sel_bit_mux   = 1'b0;
      sel_shift_mux = 1'b0;
      shift_dir     = 1'b0;
      shift_mode    = 1'b0;
      sel_out_mux   = 4'd6;
      busy          = 1'b0;
      done          = 1'b0;
      wr_en         = 1'b0;
      byte_sel      = 1'b0;
      eff_op        = op_q;
      if (state_q == S_EXEC || state_q == S_EXEC_HI) begin
         busy  = 1'b1;
         wr_en = (op_q != OP_CMP);
         if (state_q == S_EXEC_HI) begin
            byte_sel = 1'b1;
            done     = 1'b1;
            eff_op   = (op_q == OP_SUB16) ? OP_SBC : OP_ADC;
         end else begin
            done   = !(op_q == OP_ADD16 || op_q == OP_SUB16);
            if (op_q == OP_ADD16) eff_op = OP_ADD;
            if (op_q == OP_SUB16) eff_op = OP_SUB;
         end
         case (eff_op)
            OP_NOT:  sel_out_mux = 4'd0;
            OP_AND:  sel_out_mux = 4'd1;
            OP_OR:   sel_out_mux = 4'd2;
            OP_XOR:  sel_out_mux = 4'd3;
            OP_ADD:  sel_out_mux = 4'd4;
            OP_ADC: begin
               sel_out_mux = 4'd4;
               sel_bit_mux = c_q;
            end
            OP_SUB, OP_CMP: begin
               sel_out_mux = 4'd4;
               sel_b_mux   = 1'b1;
               sel_bit_mux = 1'b1;
            end
            OP_SBC: begin
               sel_out_mux = 4'd4;
               sel_b_mux   = 1'b1;
               sel_bit_mux = c_q;
            end
            OP_LSL1: begin
               sel_out_mux = 4'd5;
               sel_bit_mux = 1'b1;
            end
            OP_LSR1: begin
               sel_out_mux = 4'd5;
               sel_bit_mux = 1'b1;
               shift_dir   = 1'b1;
            end
            OP_ASR1: begin
               sel_out_mux = 4'd5;
               sel_bit_mux = 1'b1;
               shift_dir   = 1'b1;
               shift_mode  = 1'b1;
            end
            OP_LSLB: begin
               sel_out_mux   = 4'd5;
               sel_shift_mux = 1'b1;
            end
            OP_CLR: begin
               sel_out_mux  = 4'd6;
               sel_gd_b_mux = 1'b1;
            end
            default: sel_out_mux = 4'd6;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: the sequencer drives a behavioural 8-bit ALU and a
// two-byte operand/result file; results and flags are checked against
// hand-computed constants.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] op_i = 4'd0;
   logic [2:0] alu_flags;
   logic       sel_a_mux, sel_b_mux, sel_gd_b_mux, sel_bit_mux, sel_shift_mux;
   logic       shift_dir, shift_mode;
   logic [3:0] sel_out_mux;
   logic [2:0] flags_q;
   logic       busy, done, wr_en, byte_sel;

   logic [15:0] opa = 16'h0000;
   logic [15:0] opb = 16'h0000;
   logic [7:0]  a_b, b_b, b_eff, alu_r, sh_r;
   logic [8:0]  sum9;
   logic [2:0]  shamt;
   logic signed [7:0] a_s;
   logic [7:0]  res_lo = 8'h00;
   logic [7:0]  res_hi = 8'h00;
   int          wr_cnt = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   alu_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op_i), .alu_flags(alu_flags),
      .sel_a_mux(sel_a_mux), .sel_b_mux(sel_b_mux), .sel_gd_b_mux(sel_gd_b_mux),
      .sel_bit_mux(sel_bit_mux), .sel_shift_mux(sel_shift_mux),
      .shift_dir(shift_dir), .shift_mode(shift_mode), .sel_out_mux(sel_out_mux),
      .flags_q(flags_q), .busy(busy), .done(done), .wr_en(wr_en), .byte_sel(byte_sel)
   );

   // Behavioural 8-bit ALU datapath
   always_comb begin
      a_b   = byte_sel ? opa[15:8] : opa[7:0];
      b_b   = byte_sel ? opb[15:8] : opb[7:0];
      if (sel_a_mux) a_b = 8'h00;
      b_eff = sel_gd_b_mux ? 8'h00 : (sel_b_mux ? ~b_b : b_b);
      sum9  = {1'b0, a_b} + {1'b0, b_eff} + {8'h00, sel_bit_mux};
      shamt = sel_shift_mux ? b_b[2:0] : {2'b00, sel_bit_mux};
      a_s   = a_b;
      if (!shift_dir)      sh_r = a_b << shamt;
      else if (shift_mode) sh_r = a_s >>> shamt;
      else                 sh_r = a_b >> shamt;
      case (sel_out_mux)
         4'd0:    alu_r = ~a_b;
         4'd1:    alu_r = a_b & b_b;
         4'd2:    alu_r = a_b | b_b;
         4'd3:    alu_r = a_b ^ b_b;
         4'd4:    alu_r = sum9[7:0];
         4'd5:    alu_r = sh_r;
         4'd7:    alu_r = 8'hFF;
         default: alu_r = 8'h00;
      endcase
      alu_flags = {(sel_out_mux == 4'd4) ? sum9[8] : 1'b0, alu_r[7], alu_r == 8'h00};
   end

   // Result register file
   always @(posedge clk) begin
      if (wr_en) begin
         if (byte_sel) res_hi <= alu_r;
         else          res_lo <= alu_r;
         wr_cnt <= wr_cnt + 1;
      end
   end

   // Present start for one rising edge; returns #1 into the EXEC cycle
   task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start = 1'b1;
      op_i  = o;
      opa   = a;
      opb   = b;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || byte_sel !== 1'b0) begin
         n_err++;
         $display("FAIL reset_strobes: busy=%b done=%b wr_en=%b byte_sel=%b, want 0000", busy, done, wr_en, byte_sel);
      end
      n_cmp++;
      if (sel_out_mux !== 4'd6 || flags_q !== 3'b000) begin
         n_err++;
         $display("FAIL reset_out_flags: out=%0d flags=%b, want 6 000", sel_out_mux, flags_q);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add8;
      issue(4'd4, 16'h00F0, 16'h0020);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b1 || wr_en !== 1'b1 || byte_sel !== 1'b0 || sel_out_mux !== 4'd4) begin
         n_err++;
         $display("FAIL add8_exec: busy=%b done=%b wr_en=%b byte_sel=%b out=%0d, want 1110 4", busy, done, wr_en, byte_sel, sel_out_mux);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || res_lo !== 8'h10 || flags_q !== 3'b100) begin
         n_err++;
         $display("FAIL add8_result: busy=%b res=%h flags=%b, want 0 10 100", busy, res_lo, flags_q);
      end
   endtask

   task automatic test_add16;
      issue(4'd13, 16'h01FF, 16'h0001);
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || byte_sel !== 1'b0 || wr_en !== 1'b1) begin
         n_err++;
         $display("FAIL add16_lo_ctl: busy=%b done=%b byte_sel=%b wr_en=%b, want 1001", busy, done, byte_sel, wr_en);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'h00 || flags_q !== 3'b101) begin
         n_err++;
         $display("FAIL add16_lo: res=%h flags=%b, want 00 101", res_lo, flags_q);
      end
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b1 || byte_sel !== 1'b1 || sel_bit_mux !== 1'b1) begin
         n_err++;
         $display("FAIL add16_hi_ctl: busy=%b done=%b byte_sel=%b cin=%b, want 1111", busy, done, byte_sel, sel_bit_mux);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || res_hi !== 8'h02 || flags_q !== 3'b000) begin
         n_err++;
         $display("FAIL add16_hi: busy=%b res=%h flags=%b, want 0 02 000", busy, res_hi, flags_q);
      end
   endtask

   task automatic test_sub16;
      issue(4'd14, 16'h0100, 16'h0100);
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (res_lo !== 8'h00 || res_hi !== 8'h00 || flags_q !== 3'b101) begin
         n_err++;
         $display("FAIL sub16_equal: res=%h%h flags=%b, want 0000 101", res_hi, res_lo, flags_q);
      end
      issue(4'd14, 16'h0100, 16'h0001);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'hFF || flags_q !== 3'b010) begin
         n_err++;
         $display("FAIL sub16_lo_borrow: res=%h flags=%b, want ff 010", res_lo, flags_q);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (res_hi !== 8'h00 || flags_q !== 3'b100) begin
         n_err++;
         $display("FAIL sub16_z16: res_hi=%h flags=%b, want 00 100", res_hi, flags_q);
      end
   endtask

   task automatic test_cmp_and;
      int c0;
      c0 = wr_cnt;
      issue(4'd12, 16'h0005, 16'h0007);
      n_cmp++;
      if (wr_en !== 1'b0 || done !== 1'b1 || sel_b_mux !== 1'b1) begin
         n_err++;
         $display("FAIL cmp_exec: wr_en=%b done=%b sel_b=%b, want 0 1 1", wr_en, done, sel_b_mux);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (flags_q !== 3'b010 || wr_cnt !== c0) begin
         n_err++;
         $display("FAIL cmp_flags: flags=%b writes=%0d, want 010 %0d", flags_q, wr_cnt, c0);
      end
      issue(4'd1, 16'h000F, 16'h003C);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'h0C || flags_q !== 3'b010) begin
         n_err++;
         $display("FAIL and_hold: res=%h flags=%b, want 0c 010", res_lo, flags_q);
      end
   endtask

   task automatic test_shifts;
      issue(4'd10, 16'h0090, 16'h0000);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'hC8) begin
         n_err++;
         $display("FAIL asr1: res=%h, want c8", res_lo);
      end
      issue(4'd9, 16'h0090, 16'h0000);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'h48) begin
         n_err++;
         $display("FAIL lsr1: res=%h, want 48", res_lo);
      end
      issue(4'd11, 16'h0090, 16'h0003);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'h80 || flags_q !== 3'b010) begin
         n_err++;
         $display("FAIL lslb: res=%h flags=%b, want 80 010", res_lo, flags_q);
      end
   endtask

   task automatic test_start_ignored;
      issue(4'd1, 16'h000F, 16'h003C);
      start = 1'b1;
      op_i  = 4'd4;
      @(posedge clk);
      #1 start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || flags_q !== 3'b010 || res_lo !== 8'h0C) begin
         n_err++;
         $display("FAIL start_busy: busy=%b flags=%b res=%h, want 0 010 0c", busy, flags_q, res_lo);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL start_queued: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      int c0;
      c0 = wr_cnt;
      issue(4'd13, 16'h01FF, 16'h0001);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || wr_en !== 1'b0 || byte_sel !== 1'b0 || sel_out_mux !== 4'd6 || flags_q !== 3'b000) begin
         n_err++;
         $display("FAIL reset_mid: busy=%b wr_en=%b byte_sel=%b out=%0d flags=%b, want 000 6 000", busy, wr_en, byte_sel, sel_out_mux, flags_q);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (wr_cnt !== c0 + 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_write: writes=%0d busy=%b, want %0d 0", wr_cnt, busy, c0 + 1);
      end
      @(negedge clk);
      reset = 1'b0;
      issue(4'd4, 16'h007F, 16'h0001);
      @(posedge clk); #1;
      n_cmp++;
      if (res_lo !== 8'h80 || flags_q !== 3'b010) begin
         n_err++;
         $display("FAIL post_reset_add: res=%h flags=%b, want 80 010", res_lo, flags_q);
      end
   endtask

   initial begin
      test_reset();
      test_add8();
      test_add16();
      test_sub16();
      test_cmp_and();
      test_shifts();
      test_start_ignored();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
